// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only target: FSM states, R/W encodings
// and the minimum SCL phase length the oversampling front end can follow.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    A_ACK     = 3'd2,
    DATA      = 3'd3,
    D_ACK     = 3'd4,
    WAIT_STOP = 3'd5
  } state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // SCL high and low phases must each last at least this many sys_clk cycles
  localparam int MIN_SCL_PHASE = 4;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for one asynchronous bus line, plus a delay flop that
// turns the synchronised level into single-cycle rise/fall strobes.
module i2c_sync_edge (
  input  logic sys_clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta_p0;
  logic r_sync_p1;
  logic r_prev_p2;

  // Idle bus level is high, so all stages reset to 1 to avoid a false edge
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_meta_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
      r_prev_p2 <= 1'b1;
    end else begin
      r_meta_p0 <= i_async;
      r_sync_p1 <= r_meta_p0;
      r_prev_p2 <= r_sync_p1;
    end
  end

  assign o_level = r_sync_p1;
  assign o_rise  = r_sync_p1 & ~r_prev_p2;
  assign o_fall  = ~r_sync_p1 & r_prev_p2;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: decodes START/STOP, matches the address, ACKs it and
// every following data byte, and hands each byte out with a one-cycle pulse.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = ADDR_W'(8'hA4)
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       stop_det,
  output logic       busy
);

  localparam logic [3:0] ADDR_BITS = 4'(ADDR_W + 1);
  localparam logic [3:0] DATA_BITS = 4'd8;

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_addr_match;

  state_t          r_state,  w_state_nxt;
  logic [3:0]      r_cnt,    w_cnt_nxt;
  logic [ADDR_W:0] r_shift,  w_shift_nxt;
  logic            r_sda_oe, w_sda_oe_nxt;
  logic            r_hit,    w_hit_nxt;
  logic [7:0]      r_rx_data, w_rx_data_nxt;
  logic            r_rx_valid, w_rx_valid_nxt;
  logic            r_stop_det, w_stop_det_nxt;
  logic            r_busy,   w_busy_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  i2c_sync_edge u_scl (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_async (scl_in),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge u_sda (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_async (sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // Our own ACK drive must never be mistaken for a bus condition
  assign w_start      = ~r_sda_oe & w_scl_lvl & w_sda_fall;
  assign w_stop       = ~r_sda_oe & w_scl_lvl & w_sda_rise;
  assign w_addr_match = (r_shift[ADDR_W:1] == SLAVE_ADDR) && (r_shift[0] == I2C_WRITE);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_sda_oe_nxt   = r_sda_oe;
    w_hit_nxt      = r_hit;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_stop_det_nxt = 1'b0;

    if (w_stop) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_sda_oe_nxt   = 1'b0;
      w_hit_nxt      = 1'b0;
      w_stop_det_nxt = 1'b1;
    end else if (w_start) begin
      w_state_nxt  = ADDR;
      w_cnt_nxt    = '0;
      w_shift_nxt  = '0;
      w_sda_oe_nxt = 1'b0;
      w_hit_nxt    = 1'b0;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_scl_rise) begin
            if (r_cnt < ADDR_BITS) w_shift_nxt = {r_shift[ADDR_W-1:0], w_sda_lvl};
            w_cnt_nxt = sat_inc(r_cnt, ADDR_BITS);
          end else if (w_scl_fall && (r_cnt == ADDR_BITS)) begin
            w_cnt_nxt = '0;
            if (w_addr_match) begin
              w_state_nxt  = A_ACK;
              w_sda_oe_nxt = 1'b1;
              w_hit_nxt    = 1'b1;
            end else begin
              w_state_nxt  = WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        // A non-zero count marks that the ACK clock has been sampled
        A_ACK, D_ACK: begin
          if (w_scl_rise) begin
            w_cnt_nxt = sat_inc(r_cnt, 4'd1);
          end else if (w_scl_fall && (r_cnt != '0)) begin
            w_state_nxt  = DATA;
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = 1'b0;
          end
        end
        DATA: begin
          if (w_scl_rise) begin
            if (r_cnt < DATA_BITS) w_shift_nxt = {r_shift[ADDR_W-1:0], w_sda_lvl};
            w_cnt_nxt = sat_inc(r_cnt, DATA_BITS);
          end else if (w_scl_fall && (r_cnt == DATA_BITS)) begin
            w_state_nxt    = D_ACK;
            w_cnt_nxt      = '0;
            w_rx_data_nxt  = r_shift[7:0];
            w_rx_valid_nxt = 1'b1;
            w_sda_oe_nxt   = 1'b1;
          end
        end
        WAIT_STOP: w_sda_oe_nxt = 1'b0;
        IDLE:      w_sda_oe_nxt = 1'b0;
        default: begin
          w_state_nxt  = IDLE;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_hit      <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_stop_det <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_hit      <= w_hit_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_stop_det <= w_stop_det_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign addr_hit = r_hit;
  assign stop_det = r_stop_det;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a bit-banged master drives frames from a vector table
// plus hand-written repeated-START and reset-during-ACK sequences.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam int H = 5;

  typedef struct {
    logic [7:0]  addr;
    logic        rw;
    int          nbytes;
    logic [23:0] data;
    logic        exp_hit;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic       m_scl   = 1'b1;
  logic       m_sda   = 1'b1;
  logic       sda_oe, rx_valid, addr_hit, stop_det, busy;
  logic [7:0] rx_data;
  wire        sda_bus = m_sda & ~sda_oe;

  int n_checks = 0;
  int n_pass   = 0;

  int         n_valid   = 0;
  int         n_stop    = 0;
  int         n_hit_cyc = 0;
  int         n_oe_cyc  = 0;
  int         n_both    = 0;
  logic [7:0] rx_log [64];

  int         rd_ptr = 0;
  logic [7:0] exp_q [$];
  vec_t       vecs [5];

  always #5 sys_clk = ~sys_clk;

  i2c_slave_rx #(.ADDR_W(8), .SLAVE_ADDR(8'hA4)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .scl_in   (m_scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addr_hit (addr_hit),
    .stop_det (stop_det),
    .busy     (busy)
  );

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      rx_log[n_valid % 64] <= rx_data;
      n_valid <= n_valid + 1;
    end
    if (stop_det)             n_stop    <= n_stop + 1;
    if (addr_hit)             n_hit_cyc <= n_hit_cyc + 1;
    if (sda_oe)               n_oe_cyc  <= n_oe_cyc + 1;
    if (rx_valid && stop_det) n_both    <= n_both + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
  endtask

  task automatic start_c();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1; tick(3);
      m_scl = 1'b1; tick(H);
    end else begin
      m_sda = 1'b1; tick(H);
    end
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0; tick(2);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; tick(3);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b, output logic all_oe, output logic any_oe);
    m_sda = b; tick(3);
    m_scl = 1'b1;
    all_oe = 1'b1;
    any_oe = 1'b0;
    for (int i = 0; i < H; i++) begin
      tick(1);
      all_oe &= sda_oe;
      any_oe |= sda_oe;
    end
    m_scl = 1'b0; tick(2);
  endtask

  // nb payload bits MSB first, then a released ACK bit
  task automatic send_word(input logic [8:0] w, input int nb,
                           output logic ack_all, output logic ack_any, output logic data_any);
    logic a, y;
    data_any = 1'b0;
    for (int i = nb - 1; i >= 0; i--) begin
      send_bit(w[i], a, y);
      data_any |= y;
    end
    send_bit(1'b1, ack_all, ack_any);
  endtask

  task automatic drain();
    while (rd_ptr < n_valid) begin
      if (exp_q.size() > 0) check("rx_data", 32'(rx_log[rd_ptr % 64]), 32'(exp_q.pop_front()));
      rd_ptr++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int v0, s0, h0, o0;
    logic aa, ay, da;
    logic [7:0] b;
    v0 = n_valid; s0 = n_stop; h0 = n_hit_cyc; o0 = n_oe_cyc;
    start_c();
    send_word({v.addr, v.rw}, 9, aa, ay, da);
    check($sformatf("v%0d_addr_ack", idx), 32'(v.exp_hit ? aa : ay), 32'(v.exp_hit));
    check($sformatf("v%0d_addr_bits_oe", idx), 32'(da), 0);
    check($sformatf("v%0d_addr_hit", idx), 32'(addr_hit), 32'(v.exp_hit));
    if (!v.exp_hit) check($sformatf("v%0d_wait_stop", idx), 32'(dut.r_state), 32'(WAIT_STOP));
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.data[23 - 8*i -: 8];
      if (v.exp_hit) exp_q.push_back(b);
      send_word({1'b0, b}, 8, aa, ay, da);
      check($sformatf("v%0d_b%0d_ack", idx, i), 32'(v.exp_hit ? aa : ay), 32'(v.exp_hit));
      check($sformatf("v%0d_b%0d_bits_oe", idx, i), 32'(da), 0);
    end
    stop_c();
    tick(4);
    drain();
    check($sformatf("v%0d_rx_count", idx), 32'(n_valid - v0), 32'(v.exp_hit ? v.nbytes : 0));
    check($sformatf("v%0d_stop_count", idx), 32'(n_stop - s0), 1);
    check($sformatf("v%0d_hit_seen", idx), 32'(n_hit_cyc > h0), 32'(v.exp_hit));
    if (!v.exp_hit) check($sformatf("v%0d_oe_quiet", idx), 32'(n_oe_cyc - o0), 0);
    check($sformatf("v%0d_hit_clear", idx), 32'(addr_hit), 0);
    check($sformatf("v%0d_busy_idle", idx), 32'(busy), 0);
  endtask

  initial begin
    logic aa, ay, da, a, y;
    int v0;
    logic [3:0] part;

    vecs[0] = '{addr: 8'hA4, rw: 1'b0, nbytes: 1, data: 24'h3C_0000, exp_hit: 1'b1};
    vecs[1] = '{addr: 8'h55, rw: 1'b0, nbytes: 1, data: 24'hFF_0000, exp_hit: 1'b0};
    vecs[2] = '{addr: 8'hA4, rw: 1'b1, nbytes: 1, data: 24'h77_0000, exp_hit: 1'b0};
    vecs[3] = '{addr: 8'hA4, rw: 1'b0, nbytes: 3, data: 24'h11_2233, exp_hit: 1'b1};
    vecs[4] = '{addr: 8'hA5, rw: 1'b0, nbytes: 1, data: 24'hAA_0000, exp_hit: 1'b0};

    rst = 1'b0;
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_flags", 32'({rx_valid, addr_hit, stop_det, busy}), 0);
    rst = 1'b1;
    tick(5);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    check("rx_data_held", 32'(rx_data), 32'h33);

    // Repeated START after half a data byte
    v0 = n_valid;
    start_c();
    send_word({8'hA4, I2C_WRITE}, 9, aa, ay, da);
    check("rs_addr_ack", 32'(aa), 1);
    part = 4'b1010;
    for (int i = 3; i >= 0; i--) send_bit(part[i], a, y);
    start_c();
    check("rs_state_addr", 32'(dut.r_state), 32'(ADDR));
    check("rs_hit_cleared", 32'(addr_hit), 0);
    send_word({8'hA4, I2C_WRITE}, 9, aa, ay, da);
    check("rs_addr2_ack", 32'(aa), 1);
    exp_q.push_back(8'h5A);
    send_word({1'b0, 8'h5A}, 8, aa, ay, da);
    check("rs_data_ack", 32'(aa), 1);
    stop_c();
    tick(4);
    drain();
    check("rs_rx_count", 32'(n_valid - v0), 1);

    // Reset while the target is driving a data ACK
    start_c();
    send_word({8'hA4, I2C_WRITE}, 9, aa, ay, da);
    exp_q.push_back(8'hC3);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hC3 >> i), a, y);
    m_sda = 1'b1; tick(3);
    m_scl = 1'b1; tick(2);
    check("dack_oe_before_rst", 32'(sda_oe), 1);
    rst = 1'b0;
    tick(1);
    check("rst_mid_oe", 32'(sda_oe), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_rx_data", 32'(rx_data), 0);
    tick(2);
    rst = 1'b1;
    tick(10);
    drain();
    run_vec(vecs[0], 5);

    check("sb_empty", 32'(exp_q.size()), 0);
    check("no_valid_stop_overlap", 32'(n_both), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C target that sits directly downstream of the team's I2C master on the shared SCL/SDA bus.
- Oversamples SCL/SDA on sys_clk and detects START, repeated START and STOP.
- Shifts in an (ADDR_W+1)-bit address phase (address MSB first, then R/W bit) and ACKs on address match with R/W=0.
- Receives one or more data bytes, ACKs each, and presents each byte to the local logic with a one-cycle valid pulse.

Parameters:
- ADDR_W, 8, target address width; the address phase is ADDR_W+1 bits long.
- SLAVE_ADDR, 8'hA4, address this target responds to (ADDR_W bits).

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge
- rst  input  1  reset, synchronous, active-low
- scl_in  input  1  bus SCL (asynchronous to sys_clk)
- sda_in  input  1  bus SDA as read back from the pad (asynchronous)
- sda_oe  output  1  1 = pull SDA low (ACK), 0 = release; the pad ties SDA to 0 when sda_oe=1, else Z
- rx_data  output  8  last received data byte
- rx_valid  output  1  one-cycle pulse; rx_data is new
- addr_hit  output  1  high from address ACK until STOP or START
- stop_det  output  1  one-cycle pulse on every STOP condition
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0 at a sys_clk edge): state=IDLE; sync flops=1; sda_oe=0; rx_data=0; rx_valid=0; addr_hit=0; stop_det=0; bit counter=0. Reset mid-frame releases sda_oe on the same edge.
- Synchronisation: SCL and SDA each pass through 2 flops, then a third flop for edge detection. Event latency from the pin is 3 sys_clk.
- Bus timing: correct operation requires SCL high and low phases each ≥4 sys_clk. The team's master provides 5.
- Events, all on synchronised signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bit sample: SCL rising edge.
  - Bit boundary: SCL falling edge.
- States:
  - IDLE: wait for START, then go to ADDR with the bit counter cleared.
  - ADDR: shift SDA on each SCL rise, MSB first, into an (ADDR_W+1)-bit shift register. After ADDR_W+1 samples, act on the next SCL fall:
    - address == SLAVE_ADDR and R/W=0: go to A_ACK, set sda_oe=1, set addr_hit=1.
    - any other case (mismatch, or R/W=1, i.e. reads unsupported): go to WAIT_STOP with sda_oe=0 (NACK).
  - A_ACK: hold sda_oe=1 through the next SCL rise. On the following SCL fall, set sda_oe=0 and go to DATA with the bit counter cleared.
  - DATA: shift 8 bits MSB first on SCL rises. On the SCL fall after bit 8:
    - rx_data <= shift register, rx_valid=1 for exactly one cycle;
    - sda_oe=1, go to D_ACK.
  - D_ACK: hold sda_oe through the next SCL rise. On the following fall, release sda_oe and return to DATA (multi-byte write).
  - WAIT_STOP: ignore bits, sda_oe=0; a STOP or START ends the state.
- Overrides, which take priority over all state transitions:
  - STOP in any state: go to IDLE, sda_oe=0, addr_hit=0, one-cycle stop_det pulse. A partial byte is discarded with no rx_valid.
  - START (including repeated START) in any state: go to ADDR, counter=0, sda_oe=0, addr_hit=0. A partial byte is discarded.
- Own-ACK filtering: while sda_oe=1 the target ignores START/STOP detection, because its own SDA drive must not be decoded as bus events.
- Bit counter: 4 bits, saturates at the terminal count. It never wraps mid-frame.
- rx_data holds its value until the next completed byte.
- Outputs are registered. rx_valid and stop_det never assert in the same cycle.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE, ADDR, A_ACK, DATA, D_ACK, WAIT_STOP);
  - I2C_WRITE=1'b0 and I2C_READ=1'b1;
  - MIN_SCL_PHASE=4.
- Sub-module i2c_sync_edge, instanced once per line (SCL and SDA):
  - 2-flop synchroniser plus delay flop;
  - outputs: level, rise, fall.

Test Plan:
- SLAVE_ADDR=8'hA4: START, address 8'hA4 + W, byte 8'h3C, STOP
  - sda_oe=1 across both ACK clock pulses;
  - rx_data=8'h3C with exactly one rx_valid pulse;
  - addr_hit high then cleared; one stop_det pulse.
- START, address 8'h55 + W, byte 8'hFF, STOP
  - sda_oe stays 0 for the whole frame;
  - no rx_valid; addr_hit stays 0; stop_det pulses.
- START, address 8'hA4 + R
  - NACK (sda_oe=0 during the ACK bit); state goes to WAIT_STOP; no rx_valid.
- Address hit, then bytes 8'h11, 8'h22, 8'h33, then STOP
  - three rx_valid pulses carrying 11, 22, 33 in order; three data ACKs.
- Address hit, 4 data bits, repeated START, address 8'hA4 + W, byte 8'h5A
  - partial byte dropped; a single rx_valid carrying 8'h5A.
- rst=0 asserted during a data ACK
  - sda_oe=0 and busy=0 on the next edge;
  - a subsequent full frame is received correctly.
